// File: rtl/mitch_pkg.sv
// Shared definitions for the Mitchell multiplier: mode encoding and a constant-width helper.
package mitch_pkg;

  localparam logic MODE_APPROX = 1'b0;
  localparam logic MODE_EXACT  = 1'b1;

  // Bits needed to hold values 0..v-1; usable in parameter expressions.
  function automatic int clog2(input int v);
    int r;
    int t;
    r = 0;
    t = v - 1;
    while (t > 0) begin
      r++;
      t = t >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mitch_lod.sv
// Leading-one detector: returns the position k of the MSB set in v and the first
// FRAC_W fraction bits below that leading one (floor of frac(v / 2^k) * 2^FRAC_W).
module mitch_lod
  import mitch_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int FRAC_W = 6,
  localparam int KW    = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]  v,
  output logic [KW-1:0]     k,
  output logic [FRAC_W-1:0] f
);

  always_comb begin
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) k = KW'(i);
    end
  end

  // Padding v with FRAC_W zeros and shifting right by k leaves the fraction
  // bits just under the leading one in the low FRAC_W positions.
  assign f = FRAC_W'({v, {FRAC_W{1'b0}}} >> k);

endmodule

// File: rtl/mitch_mult_pipe.sv
// Three-stage valid/ready unsigned multiplier with per-beat exact or Mitchell-approximate mode.
// Define MITCH_TRUNC_COMP_EN to append a mid-point 1 bit to each truncated fraction.
module mitch_mult_pipe
  import mitch_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TRUNC_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               p_mode
);

  localparam int KW = clog2(WIDTH);
`ifdef MITCH_TRUNC_COMP_EN
  localparam int FW = TRUNC_W + 1;
`else
  localparam int FW = TRUNC_W;
`endif
  localparam int SW = FW + 1;
  localparam int AW = 2 * WIDTH + FW;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1 registers
  logic             v1;
  logic             mode1;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] y1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      mode1 <= 1'b0;
      x1    <= '0;
      y1    <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        mode1 <= mode;
        x1    <= x;
        y1    <= y;
      end
    end
  end

  logic [KW-1:0]      kx;
  logic [KW-1:0]      ky;
  logic [TRUNC_W-1:0] fx;
  logic [TRUNC_W-1:0] fy;

  mitch_lod #(.WIDTH(WIDTH), .FRAC_W(TRUNC_W)) u_lod_x (.v(x1), .k(kx), .f(fx));
  mitch_lod #(.WIDTH(WIDTH), .FRAC_W(TRUNC_W)) u_lod_y (.v(y1), .k(ky), .f(fy));

  logic [FW-1:0] fx_c;
  logic [FW-1:0] fy_c;
`ifdef MITCH_TRUNC_COMP_EN
  assign fx_c = {fx, 1'b1};
  assign fy_c = {fy, 1'b1};
`else
  assign fx_c = fx;
  assign fy_c = fy;
`endif

  logic [SW-1:0]      s_next;
  logic [KW:0]        ksum_next;
  logic [2*WIDTH-1:0] prod_next;
  logic               zero_next;

  assign s_next    = SW'(fx_c) + SW'(fy_c);
  assign ksum_next = (KW+1)'(kx) + (KW+1)'(ky);
  assign prod_next = (2*WIDTH)'(x1) * (2*WIDTH)'(y1);
  assign zero_next = (x1 == '0) || (y1 == '0);

  // Stage 2 registers
  logic               v2;
  logic               mode2;
  logic               zero2;
  logic [SW-1:0]      s2;
  logic [KW:0]        ksum2;
  logic [2*WIDTH-1:0] prod2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      mode2 <= 1'b0;
      zero2 <= 1'b0;
      s2    <= '0;
      ksum2 <= '0;
      prod2 <= '0;
    end else if (adv) begin
      v2 <= v1;
      if (v1) begin
        mode2 <= mode1;
        zero2 <= zero_next;
        s2    <= s_next;
        ksum2 <= ksum_next;
        prod2 <= prod_next;
      end
    end
  end

  // Antilog: mantissa 1.frac scaled by 2^(ksum+carry); a carry out of the
  // fraction sum already represents the leading 1, so both cases share one shift.
  logic [FW:0]        mant;
  logic [KW+1:0]      expo;
  logic [AW-1:0]      wide;
  logic [2*WIDTH-1:0] approx;
  logic [2*WIDTH-1:0] p_next;

  assign mant   = {1'b1, s2[FW-1:0]};
  assign expo   = (KW+2)'(ksum2) + (KW+2)'(s2[FW]);
  assign wide   = AW'(mant) << expo;
  assign approx = (2*WIDTH)'(wide >> FW);

  always_comb begin
    p_next = approx;
    if (zero2) p_next = '0;
    else if (mode2 == MODE_EXACT) p_next = prod2;
    else if (mode2 == MODE_APPROX) p_next = approx;
  end

  // Stage 3 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      p         <= '0;
      p_mode    <= 1'b0;
    end else if (adv) begin
      out_valid <= v2;
      if (v2) begin
        p      <= p_next;
        p_mode <= mode2;
      end
    end
  end

endmodule

// File: tb/tb_mitch_mult_pipe.sv
// Self-checking bench for mitch_mult_pipe (WIDTH=16, TRUNC_W=6): scoreboard against
// an arithmetic Mitchell model plus directed literal expectations.
module tb_mitch_mult_pipe;

  localparam int WIDTH   = 16;
  localparam int TRUNC_W = 6;
`ifdef MITCH_TRUNC_COMP_EN
  localparam int FB = TRUNC_W + 1;
`else
  localparam int FB = TRUNC_W;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;
  logic        p_mode;

  mitch_mult_pipe #(.WIDTH(WIDTH), .TRUNC_W(TRUNC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .p_mode(p_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int n_out  = 0;

  longint exp_p_q[$];
  bit     exp_m_q[$];
  longint exact_q[$];

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Mitchell product from the definition: p = floor(2^ksum*(1+s)) or floor(2^(ksum+1)*s).
  function automatic longint model_p(input longint xv, input longint yv, input bit md);
    int kx;
    int ky;
    longint fx;
    longint fy;
    longint s;
    kx = 0;
    ky = 0;
    if (xv == 0 || yv == 0) return 0;
    if (md) return xv * yv;
    while ((longint'(1) << (kx + 1)) <= xv) kx++;
    while ((longint'(1) << (ky + 1)) <= yv) ky++;
    fx = ((xv - (longint'(1) << kx)) << TRUNC_W) >> kx;
    fy = ((yv - (longint'(1) << ky)) << TRUNC_W) >> ky;
`ifdef MITCH_TRUNC_COMP_EN
    fx = 2 * fx + 1;
    fy = 2 * fy + 1;
`endif
    s = fx + fy;
    if (s < (longint'(1) << FB)) return (((longint'(1) << FB) + s) << (kx + ky)) >> FB;
    return (s << (kx + ky + 1)) >> FB;
  endfunction

  // Compare process: every cycle, check handshake and pop/push the scoreboard.
  initial begin
    longint ep;
    bit     em;
    longint ex;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_p_q.delete();
        exp_m_q.delete();
        exact_q.delete();
      end else begin
        check(in_ready == (!out_valid || out_ready), "in_ready_rule", longint'(in_ready),
              longint'(!out_valid || out_ready));
        if (out_valid && out_ready) begin
          if (exp_p_q.size() == 0) begin
            check(1'b0, "unexpected_out", longint'(p), 0);
          end else begin
            ep = exp_p_q.pop_front();
            em = exp_m_q.pop_front();
            ex = exact_q.pop_front();
            check(longint'(p) == ep, "sb_p", longint'(p), ep);
            check(p_mode == em, "sb_p_mode", longint'(p_mode), longint'(em));
`ifndef MITCH_TRUNC_COMP_EN
            if (!em) check(longint'(p) <= ex, "sb_approx_le_exact", longint'(p), ex);
`endif
            n_out++;
          end
        end
        if (in_valid && in_ready) begin
          exp_p_q.push_back(model_p(longint'(x), longint'(y), mode));
          exp_m_q.push_back(mode);
          exact_q.push_back(longint'(x) * longint'(y));
        end
      end
    end
  end

  task automatic send_beat(input logic [15:0] xv, input logic [15:0] yv, input logic md);
    bit ok;
    int guard;
    guard = 0;
    x = xv;
    y = yv;
    mode = md;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!ok && guard < 200);
    if (!ok) check(1'b0, "accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_p_q.size() != 0 || out_valid) && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 500) check(1'b0, "drain_timeout", longint'(exp_p_q.size()), 0);
  endtask

  // Single beat with literal expectation; latency counts the accepting edge as 1.
  task automatic run_one(input logic [15:0] xv, input logic [15:0] yv, input logic md,
                         input longint exp, input string name);
    int lat;
    wait_idle();
    send_beat(xv, yv, md);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(lat == 3, {name, "_latency"}, longint'(lat), 3);
    check(longint'(p) == exp, name, longint'(p), exp);
    check(p_mode == md, {name, "_p_mode"}, longint'(p_mode), longint'(md));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int guard;
    bit done;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x = '0;
    y = '0;
    mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check(out_valid == 1'b0, "reset_out_valid", longint'(out_valid), 0);
    check(p == 32'd0, "reset_p", longint'(p), 0);
    check(p_mode == 1'b0, "reset_p_mode", longint'(p_mode), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed literal vectors
`ifdef MITCH_TRUNC_COMP_EN
    run_one(16'd16, 16'd16, 1'b0, 260, "x16y16_approx");
    run_one(16'hFFFF, 16'hFFFF, 1'b0, 64'hFE000000, "xffff_sq_approx");
`else
    run_one(16'd16, 16'd16, 1'b0, 256, "x16y16_approx");
    run_one(16'hFFFF, 16'hFFFF, 1'b0, 64'hFC000000, "xffff_sq_approx");
`endif
    run_one(16'd16, 16'd16, 1'b1, 256, "x16y16_exact");
    run_one(16'd3, 16'd3, 1'b0, 8, "x3y3_approx");
    run_one(16'd3, 16'd3, 1'b1, 9, "x3y3_exact");
    run_one(16'd0, 16'hFFFF, 1'b0, 0, "zero_approx");
    run_one(16'hFFFF, 16'd0, 1'b1, 0, "zero_exact");
    run_one(16'hFFFF, 16'hFFFF, 1'b1, 64'hFFFE0001, "xffff_sq_exact");
    run_one(16'd1, 16'd1, 1'b0, 1, "x1y1_approx");

    // Ten back-to-back beats with a five-cycle downstream stall
    wait_idle();
    base = n_out;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send_beat(16'(100 + 37 * i), 16'(7 + 1000 * i), 1'(i % 2));
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check(in_ready == 1'b0, "stall_in_ready", longint'(in_ready), 0);
        out_ready = 1'b1;
      end
    join
    wait_idle();
    check(n_out - base == 10, "stall_count", longint'(n_out - base), 10);

    // Reset with three beats in flight
    wait_idle();
    for (int i = 0; i < 3; i++) send_beat(16'(5 + i), 16'(9 + i), 1'b1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check(out_valid == 1'b0, "midreset_out_valid", longint'(out_valid), 0);
    check(p == 32'd0, "midreset_p", longint'(p), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_one(16'd5, 16'd7, 1'b1, 35, "post_reset_exact");

    // Random mixed-mode traffic with random backpressure
    base = n_out;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [15:0] rx;
          logic [15:0] ry;
          rx = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
          ry = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
          send_beat(rx, ry, 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        guard = 0;
        while (!done && guard < 20000) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
          guard++;
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    wait_idle();
    check(n_out - base == 300, "random_count", longint'(n_out - base), 300);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
